// File: rtl/serial_sub4.sv
// Bit-serial subtractor D = A - B - b_in, one bit per clock, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ov.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ov
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    counter_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             br_reg;
  logic [WIDTH-1:0] d_reg;
  logic             b_out_reg;

  logic             accept;
  logic             last_step;
  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] res_next;

  assign accept      = start && (state_reg != RUN);
  assign last_step   = (state_reg == RUN) && (counter_reg == LAST);
  assign diff_bit    = a_reg[0] ^ b_reg[0] ^ br_reg;
  assign borrow_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
  assign res_next    = {diff_bit, res_reg[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (counter_reg == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands shift out LSB first, result shifts in at the MSB.
  // The visible D/b_out registers only update on the final bit-step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      br_reg      <= 1'b0;
      counter_reg <= '0;
      d_reg       <= '0;
      b_out_reg   <= 1'b0;
    end else if (accept) begin
      a_reg       <= A;
      b_reg       <= B;
      br_reg      <= b_in;
      res_reg     <= '0;
      counter_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg       <= a_reg >> 1;
      b_reg       <= b_reg >> 1;
      br_reg      <= borrow_next;
      res_reg     <= res_next;
      counter_reg <= counter_reg + 1'b1;
      if (last_step) begin
        d_reg     <= res_next;
        b_out_reg <= borrow_next;
      end
    end
  end

  assign D     = d_reg;
  assign b_out = b_out_reg;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted away during RUN, so keep copies for the overflow test.
  logic a_msb_reg;
  logic b_msb_reg;
  logic ov_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ov_reg    <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= A[WIDTH-1];
      b_msb_reg <= B[WIDTH-1];
    end else if (last_step) begin
      ov_reg <= (a_msb_reg != b_msb_reg) && (diff_bit != a_msb_reg);
    end
  end

  assign ov = ov_reg;
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: arithmetic reference model, per-cycle compare, directed literals.
module tb_serial_sub4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ov;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_sub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (op_a),
    .B     (op_b),
    .b_in  (op_bin),
    .busy  (busy),
    .done  (done),
    .D     (d),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ov    (ov)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int t;
    t = int'(a) - int'(b) - int'(bi);
    return t[W-1:0];
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    return int'(a) < (int'(b) + int'(bi));
  endfunction

  function automatic logic ref_ov(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W-1:0] r;
    r = ref_diff(a, b, bi);
    return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  // Model: a busy countdown plus the pending arithmetic result
  int           rem = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_d = '0;
  logic         m_bout = 1'b0;
  logic         m_ov = 1'b0;
  logic [W-1:0] p_d = '0;
  logic         p_bout = 1'b0;
  logic         p_ov = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem    <= 0;
      m_done <= 1'b0;
      m_d    <= '0;
      m_bout <= 1'b0;
      m_ov   <= 1'b0;
    end else if (rem > 0) begin
      rem    <= rem - 1;
      m_done <= (rem == 1);
      if (rem == 1) begin
        m_d    <= p_d;
        m_bout <= p_bout;
        m_ov   <= p_ov;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        rem    <= W;
        p_d    <= ref_diff(op_a, op_b, op_bin);
        p_bout <= ref_borrow(op_a, op_b, op_bin);
        p_ov   <= ref_ov(op_a, op_b, op_bin);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(rem > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("D", 32'(d), 32'(m_d));
      chk("b_out", 32'(b_out), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
      chk("ov", 32'(ov), 32'(m_ov));
`endif
    end
  end

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    @(posedge clk); #2;
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    op_bin = bi;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no done within %0d cycles", n);
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic [W-1:0] exp_d, input logic exp_b);
    int n;
    do_start(a, b, bi);
    wait_done(n);
    chk({name, "_D"}, 32'(d), 32'(exp_d));
    chk({name, "_bout"}, 32'(b_out), 32'(exp_b));
    $display("op %s: A=%b B=%b bin=%b -> D=%b b_out=%b", name, a, b, bi, d, b_out);
  endtask

  initial begin
    int n;
    int cnt;

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_D", 32'(d), 32'd0);
    chk("rst_bout", 32'(b_out), 32'd0);

    // Latency: done is seen exactly W+1 cycles after the start edge
    do_start(4'b0101, 4'b0011, 1'b0);
    wait_done(n);
    chk("latency", 32'(n), 32'd5);
    chk("t1_D", 32'(d), 32'b0010);
    chk("t1_bout", 32'(b_out), 32'd0);

    run_op("t2", 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1);
    run_op("t3", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);

    // A start issued during RUN must be ignored
    do_start(4'b0110, 4'b0001, 1'b0);
    @(posedge clk); #2;
    start = 1'b1;
    op_a  = 4'b1111;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(n);
    chk("ign_D", 32'(d), 32'b0101);
    chk("ign_bout", 32'(b_out), 32'd0);
    count_dones(8, cnt);
    chk("ign_single_done", 32'(cnt), 32'd0);

    // Reset in the middle of RUN aborts the operation
    do_start(4'b1001, 4'b0100, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_D", 32'(d), 32'd0);
    chk("abort_bout", 32'(b_out), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    count_dones(8, cnt);
    chk("abort_no_done", 32'(cnt), 32'd0);
    run_op("t5", 4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ov1", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0);
    chk("ov1_ov", 32'(ov), 32'd1);
    run_op("ov2", 4'b0111, 4'b0001, 1'b0, 4'b0110, 1'b0);
    chk("ov2_ov", 32'(ov), 32'd0);
`endif

    // Held start: back-to-back operations, the second begins in the DONE cycle
    @(posedge clk); #2;
    start  = 1'b1;
    op_a   = 4'b1100;
    op_b   = 4'b0101;
    op_bin = 1'b1;
    repeat (2 * (W + 1)) @(posedge clk);
    #2 start = 1'b0;
    wait_done(n);
    chk("held_D", 32'(d), 32'b0110);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      start  = ($urandom_range(0, 2) == 0);
      op_a   = W'($urandom);
      op_b   = W'($urandom);
      op_bin = 1'($urandom);
      reset  = ($urandom_range(0, 120) == 0);
      if (done)
        $display("rnd %0d: D=%b b_out=%b", i, d, b_out);
    end
    @(posedge clk); #2;
    start = 1'b0;
    reset = 1'b0;
    repeat (3 * W) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
